// File: rtl/bitstream_pc_ctrl_pkg.sv
// Shared encodings for the bitstream bit-pointer controller: command modes and FSM states.
package bs_pc_pkg;

  typedef enum logic [1:0] {
    MODE_ADV   = 2'd0,
    MODE_ALIGN = 2'd1,
    MODE_LOAD  = 2'd2,
    MODE_NOP   = 2'd3
  } cmd_mode_e;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  localparam int STALL_CNT_W = 16;

endpackage

// File: rtl/bitstream_pc_ctrl_if.sv
// Command, buffer-write and status bundle between the parser front end and the pointer controller.
interface bitstream_pc_ctrl_if #(
  parameter int PC_W     = 32,
  parameter int LEN_W    = 5,
  parameter int NSRC     = 4,
  parameter int BUF_BITS = 256
);
  import bs_pc_pkg::*;

  localparam int AV_W  = $clog2(BUF_BITS + 1);
  localparam int SRC_W = $clog2(NSRC);

  logic                   cmd_valid;
  logic                   cmd_ready;
  cmd_mode_e              cmd_mode;
  logic [SRC_W-1:0]       cmd_src;
  logic [NSRC*LEN_W-1:0]  src_len;
  logic [PC_W-1:0]        load_pc;
  logic                   wr_valid;
  logic                   wr_ready;
  logic [PC_W-1:0]        pc;
  logic [AV_W-1:0]        avail_bits;
  logic                   flush;
  logic [STALL_CNT_W-1:0] stall_cnt;

  modport master (
    output cmd_valid, cmd_mode, cmd_src, src_len, load_pc, wr_valid,
    input  cmd_ready, wr_ready, pc, avail_bits, flush, stall_cnt
  );

  modport slave (
    input  cmd_valid, cmd_mode, cmd_src, src_len, load_pc, wr_valid,
    output cmd_ready, wr_ready, pc, avail_bits, flush, stall_cnt
  );

endinterface

// File: rtl/bitstream_pc_ctrl_len_sel.sv
// Required-length selector: how many bits the current command wants to consume.
module bs_pc_len_sel
  import bs_pc_pkg::*;
#(
  parameter int LEN_W = 5,
  parameter int NSRC  = 4,
  parameter int SRC_W = $clog2(NSRC)
) (
  input  cmd_mode_e             i_cmd_mode,
  input  logic [SRC_W-1:0]      i_cmd_src,
  input  logic [NSRC*LEN_W-1:0] i_src_len,
  input  logic [2:0]            i_pc_lo,
  output logic [LEN_W-1:0]      o_len
);

  // Distance to the next byte boundary; wraps to 0 when already aligned.
  logic [2:0] w_align;
  assign w_align = 3'd0 - i_pc_lo;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    o_len = '0;
    case (i_cmd_mode)
      MODE_ADV:   o_len = i_src_len[int'(i_cmd_src)*LEN_W +: LEN_W];
      MODE_ALIGN: o_len = LEN_W'(w_align);
      default:    o_len = '0;
    endcase
  end

endmodule

// File: rtl/bitstream_pc_ctrl.sv
// Bitstream bit-pointer controller: advances/aligns/loads the pointer and tracks buffered bits.
module bitstream_pc_ctrl
  import bs_pc_pkg::*;
#(
  parameter int PC_W     = 32,
  parameter int LEN_W    = 5,
  parameter int NSRC     = 4,
  parameter int WORD_W   = 32,
  parameter int BUF_BITS = 256
) (
  input  logic                clk,
  input  logic                reset,
  bitstream_pc_ctrl_if.slave  bus
);

  localparam int AV_W = $clog2(BUF_BITS + 1);

  // One extra bit so avail + WORD_W never overflows during the headroom test.
  typedef logic [AV_W:0] av_ext_t;

  state_e                 r_state;
  logic [PC_W-1:0]        r_pc;
  logic [AV_W-1:0]        r_avail;
  logic                   r_flush;
  logic [STALL_CNT_W-1:0] r_stall_cnt;

  logic [LEN_W-1:0] w_len;
  logic             w_is_load;
  logic             w_cmd_ready;
  logic             w_wr_ready;
  logic             w_cmd_acc;
  logic             w_wr_acc;
  logic             w_consumes;
  av_ext_t          w_avail_ext;
  av_ext_t          w_avail_nxt;

  bs_pc_len_sel #(
    .LEN_W (LEN_W),
    .NSRC  (NSRC)
  ) u_len_sel (
    .i_cmd_mode (bus.cmd_mode),
    .i_cmd_src  (bus.cmd_src),
    .i_src_len  (bus.src_len),
    .i_pc_lo    (r_pc[2:0]),
    .o_len      (w_len)
  );

  assign w_is_load   = (bus.cmd_mode == MODE_LOAD);
  assign w_avail_ext = av_ext_t'(r_avail);

  assign w_cmd_ready = (r_state != ST_FLUSH) &&
                       (w_is_load || ({{LEN_W{1'b0}}, r_avail} >= {{AV_W{1'b0}}, w_len}));
  assign w_wr_ready  = (r_state != ST_FLUSH) &&
                       ((w_avail_ext + av_ext_t'(WORD_W)) <= av_ext_t'(BUF_BITS));

  assign w_cmd_acc  = bus.cmd_valid && w_cmd_ready;
  assign w_wr_acc   = bus.wr_valid && w_wr_ready;
  assign w_consumes = w_cmd_acc && ((bus.cmd_mode == MODE_ADV) || (bus.cmd_mode == MODE_ALIGN));

  assign w_avail_nxt = w_avail_ext
                     - (w_consumes ? av_ext_t'(w_len)  : '0)
                     + (w_wr_acc   ? av_ext_t'(WORD_W) : '0);

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values;
  // later assignments in the block (the LOAD override) take precedence.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_RUN;
      r_pc        <= '0;
      r_avail     <= '0;
      r_flush     <= 1'b0;
      r_stall_cnt <= '0;
    end else begin
      r_flush <= 1'b0;
      r_avail <= AV_W'(w_avail_nxt);

      if (w_consumes)
        r_pc <= r_pc + PC_W'(w_len);

      if ((r_state == ST_STALL) && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + 1'b1;

      case (r_state)
        ST_RUN:   if (bus.cmd_valid && !w_cmd_ready) r_state <= ST_STALL;
        ST_STALL: if (!bus.cmd_valid || w_cmd_ready) r_state <= ST_RUN;
        ST_FLUSH: r_state <= ST_RUN;
        default:  r_state <= ST_RUN;
      endcase

      // A LOAD restarts the stream: pointer, buffer and stall statistics all start over.
      if (w_cmd_acc && w_is_load) begin
        r_pc        <= bus.load_pc;
        r_avail     <= '0;
        r_stall_cnt <= '0;
        r_flush     <= 1'b1;
        r_state     <= ST_FLUSH;
      end
    end
  end

  assign bus.cmd_ready  = w_cmd_ready;
  assign bus.wr_ready   = w_wr_ready;
  assign bus.pc         = r_pc;
  assign bus.avail_bits = r_avail;
  assign bus.flush      = r_flush;
  assign bus.stall_cnt  = r_stall_cnt;

endmodule

// File: tb/tb_bitstream_pc_ctrl.sv
// Directed self-checking bench for bitstream_pc_ctrl: advance, align, stall, load, wrap and reset.
module tb_bitstream_pc_ctrl;
  import bs_pc_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  bitstream_pc_ctrl_if #(.PC_W(32), .LEN_W(5), .NSRC(4), .BUF_BITS(256)) bus ();

  bitstream_pc_ctrl #(
    .PC_W(32), .LEN_W(5), .NSRC(4), .WORD_W(32), .BUF_BITS(256)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.cmd_valid = 1'b0;
    bus.cmd_mode  = MODE_NOP;
    bus.cmd_src   = 2'd0;
    bus.load_pc   = 32'd0;
    bus.wr_valid  = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    bus.src_len = '0;
    do_reset();
    checks++; if (bus.pc !== 32'd0) begin errors++; $display("FAIL reset_pc: got %0h want 0", bus.pc); end
    checks++; if (bus.avail_bits !== 9'd0) begin errors++; $display("FAIL reset_avail: got %0d want 0", bus.avail_bits); end
    checks++; if (bus.flush !== 1'b0) begin errors++; $display("FAIL reset_flush: got %0b want 0", bus.flush); end
    checks++; if (bus.stall_cnt !== 16'd0) begin errors++; $display("FAIL reset_stall: got %0d want 0", bus.stall_cnt); end
    checks++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready: got %0b want 1", bus.cmd_ready); end
    checks++; if (bus.wr_ready !== 1'b1) begin errors++; $display("FAIL reset_wr_ready: got %0b want 1", bus.wr_ready); end
  endtask

  task automatic test_adv();
    bus.src_len = {5'd31, 5'd20, 5'd13, 5'd3};
    bus.wr_valid = 1'b1;
    tick();
    tick();
    bus.wr_valid = 1'b0;
    checks++; if (bus.avail_bits !== 9'd64) begin errors++; $display("FAIL adv_fill: got %0d want 64", bus.avail_bits); end
    bus.cmd_valid = 1'b1;
    bus.cmd_mode  = MODE_ADV;
    bus.cmd_src   = 2'd1;
    #1;
    checks++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL adv_ready: got %0b want 1", bus.cmd_ready); end
    tick();
    checks++; if (bus.pc !== 32'd13) begin errors++; $display("FAIL adv_pc: got %0d want 13", bus.pc); end
    checks++; if (bus.avail_bits !== 9'd51) begin errors++; $display("FAIL adv_avail: got %0d want 51", bus.avail_bits); end
  endtask

  task automatic test_align();
    bus.cmd_mode = MODE_ALIGN;
    tick();
    checks++; if (bus.pc !== 32'd16) begin errors++; $display("FAIL align_pc: got %0d want 16", bus.pc); end
    checks++; if (bus.avail_bits !== 9'd48) begin errors++; $display("FAIL align_avail: got %0d want 48", bus.avail_bits); end
    checks++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL align_aligned_ready: got %0b want 1", bus.cmd_ready); end
    tick();
    checks++; if (bus.pc !== 32'd16) begin errors++; $display("FAIL align_again_pc: got %0d want 16", bus.pc); end
    checks++; if (bus.avail_bits !== 9'd48) begin errors++; $display("FAIL align_again_avail: got %0d want 48", bus.avail_bits); end
    idle();
  endtask

  task automatic test_stall();
    do_reset();
    bus.src_len = {5'd16, 5'd8, 5'd9, 5'd27};
    bus.wr_valid = 1'b1;
    tick();
    bus.wr_valid  = 1'b0;
    bus.cmd_valid = 1'b1;
    bus.cmd_mode  = MODE_ADV;
    bus.cmd_src   = 2'd0;
    tick();
    checks++; if (bus.avail_bits !== 9'd5) begin errors++; $display("FAIL stall_setup_avail: got %0d want 5", bus.avail_bits); end
    bus.cmd_src = 2'd1;
    for (int c = 1; c <= 3; c++) begin
      #1;
      checks++; if (bus.cmd_ready !== 1'b0) begin errors++; $display("FAIL stall_ready_c%0d: got %0b want 0", c, bus.cmd_ready); end
      bus.wr_valid = (c == 3);
      tick();
      bus.wr_valid = 1'b0;
    end
    checks++; if (bus.stall_cnt !== 16'd2) begin errors++; $display("FAIL stall_cnt_mid: got %0d want 2", bus.stall_cnt); end
    checks++; if (bus.avail_bits !== 9'd37) begin errors++; $display("FAIL stall_write_avail: got %0d want 37", bus.avail_bits); end
    checks++; if (bus.pc !== 32'd27) begin errors++; $display("FAIL stall_pc_held: got %0d want 27", bus.pc); end
    #1;
    checks++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL stall_release_ready: got %0b want 1", bus.cmd_ready); end
    tick();
    checks++; if (bus.pc !== 32'd36) begin errors++; $display("FAIL stall_accept_pc: got %0d want 36", bus.pc); end
    checks++; if (bus.avail_bits !== 9'd28) begin errors++; $display("FAIL stall_accept_avail: got %0d want 28", bus.avail_bits); end
    checks++; if (bus.stall_cnt !== 16'd3) begin errors++; $display("FAIL stall_cnt_final: got %0d want 3", bus.stall_cnt); end
  endtask

  task automatic test_back_to_back();
    bus.cmd_src = 2'd2;
    tick();
    checks++; if (bus.avail_bits !== 9'd20) begin errors++; $display("FAIL b2b_first_avail: got %0d want 20", bus.avail_bits); end
    bus.cmd_src  = 2'd3;
    bus.wr_valid = 1'b1;
    #1;
    checks++; if (bus.wr_ready !== 1'b1) begin errors++; $display("FAIL b2b_wr_ready: got %0b want 1", bus.wr_ready); end
    tick();
    checks++; if (bus.avail_bits !== 9'd36) begin errors++; $display("FAIL b2b_avail: got %0d want 36", bus.avail_bits); end
    checks++; if (bus.pc !== 32'd60) begin errors++; $display("FAIL b2b_pc: got %0d want 60", bus.pc); end
    checks++; if (bus.stall_cnt !== 16'd3) begin errors++; $display("FAIL b2b_stall_hold: got %0d want 3", bus.stall_cnt); end
    idle();
  endtask

  task automatic test_load();
    bus.cmd_valid = 1'b1;
    bus.cmd_mode  = MODE_LOAD;
    bus.load_pc   = 32'h100;
    bus.wr_valid  = 1'b1;
    #1;
    checks++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL load_ready: got %0b want 1", bus.cmd_ready); end
    tick();
    bus.cmd_mode = MODE_NOP;
    #1;
    checks++; if (bus.pc !== 32'h100) begin errors++; $display("FAIL load_pc: got %0h want 100", bus.pc); end
    checks++; if (bus.avail_bits !== 9'd0) begin errors++; $display("FAIL load_avail: got %0d want 0", bus.avail_bits); end
    checks++; if (bus.flush !== 1'b1) begin errors++; $display("FAIL load_flush: got %0b want 1", bus.flush); end
    checks++; if (bus.stall_cnt !== 16'd0) begin errors++; $display("FAIL load_stall_clr: got %0d want 0", bus.stall_cnt); end
    checks++; if (bus.cmd_ready !== 1'b0) begin errors++; $display("FAIL flush_cmd_ready: got %0b want 0", bus.cmd_ready); end
    checks++; if (bus.wr_ready !== 1'b0) begin errors++; $display("FAIL flush_wr_ready: got %0b want 0", bus.wr_ready); end
    tick();
    checks++; if (bus.flush !== 1'b0) begin errors++; $display("FAIL flush_pulse_end: got %0b want 0", bus.flush); end
    checks++; if (bus.avail_bits !== 9'd0) begin errors++; $display("FAIL flush_write_dropped: got %0d want 0", bus.avail_bits); end
    checks++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL post_flush_cmd_ready: got %0b want 1", bus.cmd_ready); end
    checks++; if (bus.wr_ready !== 1'b1) begin errors++; $display("FAIL post_flush_wr_ready: got %0b want 1", bus.wr_ready); end
    idle();
  endtask

  task automatic test_wrap();
    bus.cmd_valid = 1'b1;
    bus.cmd_mode  = MODE_LOAD;
    bus.load_pc   = 32'hFFFF_FFF8;
    tick();
    idle();
    tick();
    bus.wr_valid = 1'b1;
    tick();
    bus.wr_valid  = 1'b0;
    bus.cmd_valid = 1'b1;
    bus.cmd_mode  = MODE_ADV;
    bus.cmd_src   = 2'd3;
    tick();
    checks++; if (bus.pc !== 32'h0000_0008) begin errors++; $display("FAIL wrap_pc: got %0h want 8", bus.pc); end
    checks++; if (bus.avail_bits !== 9'd16) begin errors++; $display("FAIL wrap_avail: got %0d want 16", bus.avail_bits); end
  endtask

  task automatic test_reset_mid_stall();
    bus.src_len = {5'd16, 5'd8, 5'd9, 5'd31};
    bus.cmd_src = 2'd0;
    tick();
    tick();
    tick();
    checks++; if (bus.stall_cnt !== 16'd2) begin errors++; $display("FAIL rst_stall_pre: got %0d want 2", bus.stall_cnt); end
    reset = 1'b1;
    #2;
    checks++; if (bus.pc !== 32'd0) begin errors++; $display("FAIL rst_async_pc: got %0h want 0", bus.pc); end
    checks++; if (bus.avail_bits !== 9'd0) begin errors++; $display("FAIL rst_async_avail: got %0d want 0", bus.avail_bits); end
    checks++; if (bus.stall_cnt !== 16'd0) begin errors++; $display("FAIL rst_async_stall: got %0d want 0", bus.stall_cnt); end
    checks++; if (bus.flush !== 1'b0) begin errors++; $display("FAIL rst_async_flush: got %0b want 0", bus.flush); end
    checks++; if (bus.cmd_ready !== 1'b0) begin errors++; $display("FAIL rst_async_cmd_ready: got %0b want 0", bus.cmd_ready); end
    checks++; if (bus.wr_ready !== 1'b1) begin errors++; $display("FAIL rst_async_wr_ready: got %0b want 1", bus.wr_ready); end
    idle();
    tick();
    reset = 1'b0;
    tick();
    checks++; if (bus.pc !== 32'd0) begin errors++; $display("FAIL rst_release_pc: got %0h want 0", bus.pc); end
    checks++; if (bus.stall_cnt !== 16'd0) begin errors++; $display("FAIL rst_release_stall: got %0d want 0", bus.stall_cnt); end
  endtask

  initial begin
    idle();
    bus.src_len = '0;
    test_reset();
    test_adv();
    test_align();
    test_stall();
    test_back_to_back();
    test_load();
    test_wrap();
    test_reset_mid_stall();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bitstream_pc_ctrl.md
BITSTREAM_PC_CTRL -- requirements
Module: bitstream_pc_ctrl

Interface
REQ-001 Parameter PC_W, 32, bit-pointer width.
REQ-002 Parameter LEN_W, 5, width of each per-source consumed-length field.
REQ-003 Parameter NSRC, 4, number of consumed-length sources (fixed-length, exp-Golomb, dependent-variable, CAVLC).
REQ-004 Parameter WORD_W, 32, bits added to the buffer per accepted write.
REQ-005 Parameter BUF_BITS, 256, bit capacity of the upstream buffer; AV_W = clog2(BUF_BITS+1).
REQ-006 clk  in  1  single clock; all state updates on rising edge.
REQ-007 reset  in  1  asynchronous, active-high reset.
REQ-008 cmd_valid  in  1  command present.
REQ-009 cmd_ready  out  1  command accepted this cycle when high with cmd_valid.
REQ-010 cmd_mode  in  2  0 ADV, 1 ALIGN, 2 LOAD, 3 NOP.
REQ-011 cmd_src  in  clog2(NSRC)  source index for ADV.
REQ-012 src_len  in  NSRC*LEN_W  packed lengths; source i at bits [i*LEN_W +: LEN_W].
REQ-013 load_pc  in  PC_W  new pointer for LOAD.
REQ-014 wr_valid  in  1  one WORD_W word entering buffer.
REQ-015 wr_ready  out  1  high when avail_bits + WORD_W <= BUF_BITS and state != FLUSH.
REQ-016 pc  out  PC_W  registered bit pointer.
REQ-017 avail_bits  out  AV_W  registered count of buffered, unconsumed bits.
REQ-018 flush  out  1  registered one-cycle pulse after an accepted LOAD.
REQ-019 stall_cnt  out  16  saturating count of STALL cycles.

Function
REQ-020 Required length r: ADV = src_len[cmd_src]; ALIGN = (8 - pc[2:0]) mod 8; LOAD = 0; NOP = 0.
REQ-021 cmd_ready = (state != FLUSH) and (cmd_mode == LOAD or avail_bits >= r); combinational, no dependence on cmd_valid.
REQ-022 Accepted ADV/ALIGN: pc <= pc + r modulo 2^PC_W, same edge; zero-length ADV and aligned ALIGN leave pc unchanged but are accepted.
REQ-023 avail_bits <= avail_bits - (accepted ADV/ALIGN ? r : 0) + (wr_valid and wr_ready ? WORD_W : 0); simultaneous write and consume both apply in one cycle.
REQ-024 Accepted LOAD: pc <= load_pc, avail_bits <= 0, any same-cycle write discarded, stall_cnt <= 0, flush <= 1, state <= FLUSH.
REQ-025 Accepted NOP: no pc/avail change from the command.
REQ-026 FSM states RUN, STALL, FLUSH; RUN -> STALL when cmd_valid and not cmd_ready; STALL -> RUN on accept or cmd_valid low; FLUSH -> RUN unconditionally after one cycle.
REQ-027 In FLUSH, cmd_ready = 0 and wr_ready = 0.
REQ-028 stall_cnt increments each cycle state == STALL, holds at 16'hFFFF.
REQ-029 pc wrap-around past 2^PC_W-1 is silent; no flag.
REQ-030 avail_bits never exceeds BUF_BITS and never goes negative, guaranteed by REQ-015/REQ-021.

Reset
REQ-031 On reset assertion, immediately: pc = 0, avail_bits = 0, flush = 0, stall_cnt = 0, state = RUN; combinational cmd_ready/wr_ready follow the reset state.
REQ-032 Reset mid-command or mid-STALL discards the command; no partial pc update.

Structure
REQ-033 Shared package bs_pc_pkg holds cmd_mode encodings (ADV, ALIGN, LOAD, NOP) and FSM state encodings.
REQ-034 One sub-module bs_pc_len_sel computes r from cmd_mode, cmd_src, src_len, pc[2:0]; purely combinational.

Verification
REQ-035 Reset, 2 writes (avail 64), ADV src1 len 13 -> pc 13, avail 51 next cycle.
REQ-036 pc = 13, ALIGN -> pc 16, avail decreases by 3; ALIGN again at pc 16 -> accepted, pc stays 16.
REQ-037 avail 5, ADV len 9 held 4 cycles, write on cycle 4 -> cmd_ready low 3 cycles, stall_cnt 3, accept same cycle write lands? No: accept next cycle, pc +9, avail 28.
REQ-038 Same-cycle write and ADV len 16 at avail 20 -> avail 36.
REQ-039 LOAD load_pc 0x100 with simultaneous wr_valid -> pc 0x100, avail 0, flush one cycle, cmd_ready/wr_ready low one cycle, stall_cnt 0.
REQ-040 pc 0xFFFFFFF8, ADV len 16 -> pc 0x00000008; reset asserted mid-STALL -> all outputs per REQ-031 without clock edge.
